pipe_mem_arbiter: RTL and testbench

- Shares one single-port unified RAM between the 5-stage MIPS pipeline's instruction fetch (IF) and data access (MEM) stages.
- Serialises the two requests, with data priority, and talks to a variable-latency RAM through a req/ack handshake.
- Drives the stall signals that the pipeline controller uses to freeze the IF/ID/EXE/MEM enables.
- Holds each completed access until the pipeline advances, so no access is ever issued twice.

---
 rtl/pipe_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_pipe_mem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// ============================================================================
// Module      : pipe_mem_arbiter
// Description : Arbitrates one single-port RAM between the IF and MEM stages.
//               Data has priority. Optional macro ARB_PERF_CNT_EN adds
//               performance counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_mem_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_ren,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_data,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        inst_stall,
   output logic        data_stall,
   output logic        stall,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ack,
   output logic        timeout_err
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] inst_accesses,
   output logic [31:0] data_accesses
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } state_t;

   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] wait_cnt;
   logic        inst_served;
   logic        data_served;
   logic        inst_pend;
   logic        data_pend;
   logic        done;

   assign inst_pend  = inst_ren & ~inst_served;
   assign data_pend  = (mem_ren | mem_wen) & ~data_served;
   assign inst_stall = inst_pend;
   assign data_stall = data_pend;
   assign stall      = inst_pend | data_pend;

   // An ack in the last allowed wait cycle still counts as a completion.
   assign done = (state != IDLE) && (ram_ack || (wait_cnt == LAST_WAIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         inst_served <= 1'b0;
         data_served <= 1'b0;
         ram_req     <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         inst_data   <= '0;
         mem_din     <= '0;
         timeout_err <= 1'b0;
      end else begin
         // Pipeline advance releases both held results.
         if (!stall) begin
            inst_served <= 1'b0;
            data_served <= 1'b0;
         end
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (data_pend) begin
                  ram_req   <= 1'b1;
                  ram_we    <= mem_wen;
                  ram_addr  <= mem_addr;
                  ram_wdata <= mem_dout;
                  state     <= BUSY_D;
               end else if (inst_pend) begin
                  ram_req  <= 1'b1;
                  ram_we   <= 1'b0;
                  ram_addr <= inst_addr;
                  state    <= BUSY_I;
               end
            end
            BUSY_D, BUSY_I: begin
               wait_cnt <= wait_cnt + 16'd1;
               if (done) begin
                  ram_req <= 1'b0;
                  ram_we  <= 1'b0;
                  state   <= IDLE;
                  if (!ram_ack) begin
                     timeout_err <= 1'b1;
                  end
                  if (state == BUSY_D) begin
                     data_served <= 1'b1;
                     if (!ram_we) begin
                        mem_din <= ram_ack ? ram_rdata : ERR_DATA;
                     end
                  end else begin
                     inst_served <= 1'b1;
                     inst_data   <= ram_ack ? ram_rdata : ERR_DATA;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles  <= '0;
         inst_accesses <= '0;
         data_accesses <= '0;
      end else begin
         if (stall) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (done && (state == BUSY_I)) begin
            inst_accesses <= inst_accesses + 32'd1;
         end
         if (done && (state == BUSY_D)) begin
            data_accesses <= data_accesses + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
// ============================================================================
// Module      : tb_pipe_mem_arbiter
// Description : Self-checking bench for pipe_mem_arbiter with a RAM responder
//               and a transaction-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_ren;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        inst_stall;
   logic        data_stall;
   logic        stall;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ack;
   logic        timeout_err;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] inst_accesses;
   logic [31:0] data_accesses;
`endif

   pipe_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst),
      .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_din(mem_din),
      .inst_stall(inst_stall), .data_stall(data_stall), .stall(stall),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
      .timeout_err(timeout_err)
`ifdef ARB_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .inst_accesses(inst_accesses),
      .data_accesses(data_accesses)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } acc_t;

   acc_t        log_q[$];
   int          dly_q[$];
   bit          manual;
   int          req_cycles;
   logic        auto_ack, man_ack;
   logic [31:0] auto_rdata, man_rdata;
   logic [31:0] ram     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   int          checks, failures;
   logic [31:0] exp_din, exp_inst;
   logic        exp_err;

   assign ram_ack   = manual ? man_ack : auto_ack;
   assign ram_rdata = manual ? man_rdata : auto_rdata;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h1357;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // Busy cycles of one access given its ack delay.
   function automatic int busy(input int l);
      return (l + 1 <= TO) ? l + 1 : TO;
   endfunction

   // Variable-latency RAM: each new request takes the next delay from dly_q.
   initial begin
      int  left;
      bit  active;
      auto_ack   = 1'b0;
      auto_rdata = '0;
      active     = 1'b0;
      left       = -1;
      forever begin
         @(posedge clk);
         #1;
         auto_ack = 1'b0;
         if (manual) begin
            active = 1'b0;
         end else begin
            if (ram_req) req_cycles++;
            if (!ram_req) begin
               active = 1'b0;
            end else if (!active) begin
               active = 1'b1;
               if (dly_q.size() > 0) left = dly_q.pop_front();
               else left = 0;
               log_q.push_back(acc_t'{ram_addr, ram_we, ram_wdata});
            end
            if (active && left == 0) begin
               auto_ack = 1'b1;
               if (ram_we) begin
                  auto_rdata = $urandom;
                  ram[ram_addr] = ram_wdata;
               end else begin
                  auto_rdata = ram.exists(ram_addr) ? ram[ram_addr] : dflt(ram_addr);
               end
               left = -1;
            end else if (active && left > 0) begin
               left--;
            end
         end
      end
   end

   task automatic run_txn(input string name, input bit ir, input logic [31:0] ia,
                          input bit dr, input bit dw, input logic [31:0] da,
                          input logic [31:0] wd, input int ld, input int li,
                          output int stalled);
      acc_t exp_q[$];
      int   exp_stall;
      bit   dacc, split;
      dacc      = dr | dw;
      exp_stall = 0;
      split     = 1'b0;
      dly_q.delete();
      if (dacc) begin
         exp_q.push_back(acc_t'{da, dw, wd});
         dly_q.push_back(ld);
         exp_stall += 1 + busy(ld);
         if (ld + 1 <= TO) begin
            if (dw) ref_mem[da] = wd;
            else exp_din = ref_rd(da);
         end else begin
            exp_err = 1'b1;
            if (!dw) exp_din = 32'hFFFF_FFFF;
         end
      end
      if (ir) begin
         exp_q.push_back(acc_t'{ia, 1'b0, 32'h0});
         dly_q.push_back(li);
         exp_stall += 1 + busy(li);
         if (li + 1 <= TO) exp_inst = ref_rd(ia);
         else begin
            exp_err  = 1'b1;
            exp_inst = 32'hFFFF_FFFF;
         end
      end
      log_q.delete();
      inst_ren = ir; inst_addr = ia;
      mem_ren = dr; mem_wen = dw; mem_addr = da; mem_dout = wd;
      stalled = 0;
      #1;
      while (stall && stalled < 60) begin
         stalled++;
         if (dacc && ir && !data_stall && inst_stall) split = 1'b1;
         @(negedge clk);
         #1;
      end
      checks++;
      if (stall) begin
         failures++;
         $display("FAIL %s completion: stall still %b after %0d cycles, want 0", name, stall, stalled);
      end
      checks++;
      if (stalled !== exp_stall) begin
         failures++;
         $display("FAIL %s stall_len: got %0d want %0d", name, stalled, exp_stall);
      end
      if (ir) begin
         checks++;
         if (inst_data !== exp_inst) begin
            failures++;
            $display("FAIL %s inst_data: got %h want %h", name, inst_data, exp_inst);
         end
      end
      checks++;
      if (mem_din !== exp_din) begin
         failures++;
         $display("FAIL %s mem_din: got %h want %h", name, mem_din, exp_din);
      end
      checks++;
      if (timeout_err !== exp_err) begin
         failures++;
         $display("FAIL %s timeout_err: got %b want %b", name, timeout_err, exp_err);
      end
      if (dacc && ir) begin
         checks++;
         if (!split) begin
            failures++;
            $display("FAIL %s data_first: data_stall never dropped before inst_stall, got 0 want 1", name);
         end
      end
      inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (log_q.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL %s ram_accesses: got %0d want %0d", name, log_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (log_q[k].addr !== exp_q[k].addr || log_q[k].we !== exp_q[k].we ||
                (exp_q[k].we && log_q[k].wdata !== exp_q[k].wdata)) begin
               failures++;
               $display("FAIL %s ram_access%0d: got a=%h we=%b wd=%h want a=%h we=%b wd=%h",
                        name, k, log_q[k].addr, log_q[k].we, log_q[k].wdata,
                        exp_q[k].addr, exp_q[k].we, exp_q[k].wdata);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_din = '0; exp_inst = '0; exp_err = 1'b0;
   endtask

   task automatic test_reset();
      inst_ren = 1'b0; inst_addr = '0; mem_ren = 1'b0; mem_wen = 1'b0;
      mem_addr = '0; mem_dout = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({ram_req, ram_we, ram_addr, ram_wdata, inst_data, mem_din,
           inst_stall, data_stall, stall, timeout_err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got req=%b we=%b a=%h wd=%h id=%h md=%h st=%b err=%b want all 0",
                  ram_req, ram_we, ram_addr, ram_wdata, inst_data, mem_din, stall, timeout_err);
      end
      inst_ren = 1'b1; inst_addr = 32'h40;
      @(negedge clk);
      checks++;
      if (ram_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold_req: got %b want 0", ram_req);
      end
      inst_ren = 1'b0;
      rst = 1'b0;
      exp_din = '0; exp_inst = '0; exp_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      int s;
      ram[32'h40] = 32'h2002_0005;
      ref_mem[32'h40] = 32'h2002_0005;
      req_cycles = 0;
      run_txn("fetch", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 0, 2, s);
      checks++;
      if (req_cycles !== 3) begin
         failures++;
         $display("FAIL fetch_req_cycles: got %0d want 3", req_cycles);
      end
      checks++;
      if (inst_data !== 32'h2002_0005) begin
         failures++;
         $display("FAIL fetch_value: got %h want 20020005", inst_data);
      end
   endtask

   task automatic test_simultaneous();
      int s;
`ifdef ARB_PERF_CNT_EN
      logic [31:0] sc0, ia0, da0;
      sc0 = stall_cycles; ia0 = inst_accesses; da0 = data_accesses;
`endif
      run_txn("simul", 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, 0, 0, s);
`ifdef ARB_PERF_CNT_EN
      checks++;
      if (data_accesses - da0 !== 32'd1 || inst_accesses - ia0 !== 32'd1) begin
         failures++;
         $display("FAIL perf_accesses: got d=%0d i=%0d want 1 1",
                  data_accesses - da0, inst_accesses - ia0);
      end
      checks++;
      if (stall_cycles - sc0 !== 32'(s)) begin
         failures++;
         $display("FAIL perf_stall_cycles: got %0d want %0d", stall_cycles - sc0, s);
      end
`endif
   endtask

   task automatic test_store();
      int s;
      run_txn("store", 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1, 0, s);
      run_txn("store_rb", 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 0, 0, s);
   endtask

   task automatic test_timeout();
      int s;
      do_reset();
      run_txn("ack_at_limit", 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 0, TO - 1, s);
      run_txn("timeout", 1'b1, 32'h84, 1'b0, 1'b0, 32'h0, 32'h0, 0, 50, s);
      run_txn("after_timeout", 1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0, 0, TO - 1, s);
   endtask

   task automatic test_reset_busy();
      int n;
      manual = 1'b1;
      man_ack = 1'b0; man_rdata = '0;
      mem_ren = 1'b1; mem_addr = 32'h300;
      n = 0;
      while (!ram_req && n < 5) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      exp_din = '0; exp_inst = '0; exp_err = 1'b0;
      checks++;
      if (ram_req !== 1'b0 || data_stall !== 1'b1 || timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_busy_state: got req=%b dstall=%b err=%b want 0 1 0",
                  ram_req, data_stall, timeout_err);
      end
      rst = 1'b0;
      man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      man_ack = 1'b0;
      checks++;
      if (ram_req !== 1'b1 || ram_addr !== 32'h300 || data_stall !== 1'b1 || mem_din !== 32'h0) begin
         failures++;
         $display("FAIL rst_stale_ack: got req=%b a=%h dstall=%b din=%h want 1 00000300 1 00000000",
                  ram_req, ram_addr, data_stall, mem_din);
      end
      dly_q.delete();
      dly_q.push_back(1);
      manual = 1'b0;
      n = 0;
      while (stall && n < 20) begin
         @(negedge clk);
         n++;
      end
      exp_din = ref_rd(32'h300);
      checks++;
      if (stall !== 1'b0 || mem_din !== exp_din) begin
         failures++;
         $display("FAIL rst_reissue: got stall=%b din=%h want 0 %h", stall, mem_din, exp_din);
      end
      mem_ren = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      int s, kind, ld, li;
      bit dr, dw;
      logic [31:0] ia, da, wd;
      for (int t = 0; t < 30; t++) begin
         kind = $urandom_range(0, 2);
         ia = 32'h1000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         da = 32'h1000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         wd = $urandom;
         dw = 1'($urandom_range(0, 1));
         dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
         ld = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : 20;
         li = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : 20;
         run_txn($sformatf("rand%0d", t), kind != 1, ia,
                 (kind != 0) && dr, (kind != 0) && dw, da, wd, ld, li, s);
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      manual = 1'b0; man_ack = 1'b0; man_rdata = '0;
      req_cycles = 0;
      rst = 1'b1;
      inst_ren = 1'b0; inst_addr = '0; mem_ren = 1'b0; mem_wen = 1'b0;
      mem_addr = '0; mem_dout = '0;
      exp_din = '0; exp_inst = '0; exp_err = 1'b0;
      @(negedge clk);
      test_reset();
      test_fetch();
      test_simultaneous();
      test_store();
      test_timeout();
      test_reset_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
